fir_out_decim: RTL and testbench

FIR_OUT_DECIM -- requirements
Module: fir_out_decim

---
 rtl/fir_out_decim.sv | 155 +++++++++++++++
 tb/tb_fir_out_decim.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fir_out_decim.sv
// Output stage of a FIR filter: decimate, round/saturate to W_O bits,
// and buffer the samples in a small FIFO with sticky saturation/overflow status.
module fir_out_decim #(
  parameter int W_Y   = 10,
  parameter int W_O   = 8,
  parameter int SHIFT = 2,
  parameter int D     = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [W_Y-1:0]      y,
  input  logic                       y_valid,
  output logic signed [W_O-1:0]      m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       sat_flag,
  output logic                       ovf_flag,
  output logic [7:0]                 drop_cnt,
  input  logic                       clr_flags
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic signed [W_Y:0] O_MAX = (W_Y+1)'((2**(W_O-1)) - 1);
  localparam logic signed [W_Y:0] O_MIN = (W_Y+1)'(-(2**(W_O-1)));

  logic [PW-1:0]         phase_q, phase_d;
  logic                  stg_vld_q, stg_vld_d;
  logic signed [W_O-1:0] stg_data_q, stg_data_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  sat_q, sat_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_q, drop_d;

  logic signed [W_O-1:0] mem [DEPTH];

  logic                  accept;
  logic signed [W_Y:0]   y_ext;
  logic signed [W_Y:0]   r;
  logic signed [W_O-1:0] r_clamped;
  logic                  clip;
  logic                  full;
  logic                  pop;
  logic                  wr_ok;
  logic                  drop;

  assign accept = y_valid && (phase_q == '0);
  assign y_ext  = {y[W_Y-1], y};

  // Round half up: add half an output LSB, then arithmetic shift (one guard bit absorbs the carry).
  if (SHIFT > 0) begin : g_round
    localparam logic signed [W_Y:0] HALF = (W_Y+1)'(2**(SHIFT-1));
    logic signed [W_Y:0] sum;
    assign sum = y_ext + HALF;
    assign r   = sum >>> SHIFT;
  end else begin : g_no_round
    assign r = y_ext;
  end

  always_comb begin
    r_clamped = r[W_O-1:0];
    clip      = 1'b0;
    if (r > O_MAX) begin
      r_clamped = O_MAX[W_O-1:0];
      clip      = 1'b1;
    end else if (r < O_MIN) begin
      r_clamped = O_MIN[W_O-1:0];
      clip      = 1'b1;
    end
  end

  assign m_valid = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop     = m_valid && m_ready;
  // A pop on the same edge frees the slot, so a write into a full FIFO still lands.
  assign wr_ok   = stg_vld_q && (!full || pop);
  assign drop    = stg_vld_q && full && !pop;

  always_comb begin
    phase_d    = phase_q;
    stg_vld_d  = accept;
    stg_data_d = stg_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sat_d      = (sat_q && !clr_flags) || (accept && clip);
    ovf_d      = (ovf_q && !clr_flags) || drop;
    drop_d     = clr_flags ? 8'd0 : drop_q;

    if (y_valid) begin
      phase_d = (phase_q == PW'(D - 1)) ? '0 : phase_q + 1'b1;
    end
    if (accept) begin
      stg_data_d = r_clamped;
    end
    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop && (drop_d != 8'hFF)) begin
      drop_d = drop_d + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      stg_vld_q  <= 1'b0;
      stg_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      phase_q    <= phase_d;
      stg_vld_q  <= stg_vld_d;
      stg_data_q <= stg_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= stg_data_q;
    end
  end

  // Gate the head so the output reads 0 whenever the FIFO is empty, including in reset.
  assign m_data   = m_valid ? mem[rd_ptr_q] : '0;
  assign count    = count_q;
  assign sat_flag = sat_q;
  assign ovf_flag = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fir_out_decim.sv
// Directed bench for fir_out_decim: u1 runs with D=1, u2 with the default D=2;
// both share the same stimulus.
module tb_fir_out_decim;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [9:0] y;
  logic              y_valid;
  logic              m_ready;
  logic              clr_flags;

  logic signed [7:0] m_data1, m_data2;
  logic              m_valid1, m_valid2;
  logic [2:0]        cnt1, cnt2;
  logic              sat1, sat2, ovf1, ovf2;
  logic [7:0]        drop1, drop2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fir_out_decim #(.D(1)) u1 (
    .clk(clk), .rst(rst), .y(y), .y_valid(y_valid),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready),
    .count(cnt1), .sat_flag(sat1), .ovf_flag(ovf1), .drop_cnt(drop1),
    .clr_flags(clr_flags)
  );

  fir_out_decim u2 (
    .clk(clk), .rst(rst), .y(y), .y_valid(y_valid),
    .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
    .count(cnt2), .sat_flag(sat2), .ovf_flag(ovf2), .drop_cnt(drop2),
    .clr_flags(clr_flags)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; y = '0; y_valid = 1'b0; m_ready = 1'b0; clr_flags = 1'b0;

    // Reset holds everything at zero regardless of inputs
    for (int i = 0; i < 6; i++) begin
      y         = 10'($urandom_range(1023, 0));
      y_valid   = 1'($urandom_range(1, 0));
      m_ready   = 1'($urandom_range(1, 0));
      clr_flags = 1'($urandom_range(1, 0));
      tick();
      chk("rst_valid1", m_valid1, 0);
      chk("rst_count1", cnt1, 0);
      chk("rst_data1", m_data1, 0);
      chk("rst_sat1", sat1, 0);
      chk("rst_ovf1", ovf1, 0);
      chk("rst_drop1", drop1, 0);
      chk("rst_valid2", m_valid2, 0);
      chk("rst_count2", cnt2, 0);
    end
    rst = 1'b0; y = '0; y_valid = 1'b0; m_ready = 1'b0; clr_flags = 1'b0;
    tick();

    // Decimation on u2 (D=2): 4, 8, 12, 16 -> only 1 and 3
    m_ready = 1'b1; y_valid = 1'b1;
    y = 10'sd4;  tick();
    chk("dec_empty", m_valid2, 0);
    y = 10'sd8;  tick();
    chk("dec_v0", m_valid2, 1);
    chk("dec_d0", m_data2, 1);
    y = 10'sd12; tick();
    chk("dec_gap", m_valid2, 0);
    y = 10'sd16; tick();
    chk("dec_v1", m_valid2, 1);
    chk("dec_d1", m_data2, 3);
    y_valid = 1'b0; tick();
    chk("dec_end0", m_valid2, 0);
    tick();
    chk("dec_end1", m_valid2, 0);
    tick();
    chk("dec_u1_empty", m_valid1, 0);

    // Rounding on u1 (D=1): 6, 5, -6 -> 2, 1, -1 two edges after input
    y_valid = 1'b1;
    y = 10'sd6;  tick();
    chk("rnd_lat", m_valid1, 0);
    y = 10'sd5;  tick();
    chk("rnd_d0", m_data1, 2);
    chk("rnd_c0", cnt1, 1);
    y = -10'sd6; tick();
    chk("rnd_d1", m_data1, 1);
    chk("rnd_c1", cnt1, 1);
    y_valid = 1'b0; tick();
    chk("rnd_d2", m_data1, -1);
    tick();
    chk("rnd_end", m_valid1, 0);

    // Saturation and clear, including clear colliding with a new saturation
    y_valid = 1'b1;
    y = 10'sd511; tick();
    chk("sat_set", sat1, 1);
    clr_flags = 1'b1; y = -10'sd512; tick();
    chk("sat_clr", sat1, 0);
    chk("sat_max", m_data1, 127);
    y = 10'sd511; tick();
    chk("sat_win", sat1, 1);
    chk("sat_min", m_data1, -128);
    clr_flags = 1'b0; y_valid = 1'b0; tick();
    chk("sat_max2", m_data1, 127);
    chk("sat_hold", sat1, 1);
    tick();
    chk("sat_end", m_valid1, 0);

    // Backpressure: six samples into a depth-4 FIFO with the consumer stalled
    rst = 1'b1; tick(); rst = 1'b0;
    m_ready = 1'b0; y_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      y = 10'(4 * i);
      tick();
      chk("bp_count", cnt1, (i - 1 > 4) ? 4 : i - 1);
      chk("bp_drop", drop1, (i == 6) ? 1 : 0);
      if (i >= 2) chk("bp_hold", m_data1, 1);
    end
    y_valid = 1'b0; tick();
    chk("bp_count_f", cnt1, 4);
    chk("bp_drop_f", drop1, 2);
    chk("bp_ovf", ovf1, 1);
    chk("bp_head", m_data1, 1);
    m_ready = 1'b1;
    tick(); chk("bp_drain2", m_data1, 2);
    tick(); chk("bp_drain3", m_data1, 3);
    tick(); chk("bp_drain4", m_data1, 4);
    tick();
    chk("bp_empty", m_valid1, 0);
    chk("bp_count0", cnt1, 0);

    // Full FIFO: pop and write on one edge, then a drop colliding with clear
    m_ready = 1'b0; y_valid = 1'b1;
    y = 10'sd4;  tick();
    y = 10'sd8;  tick();
    y = 10'sd12; tick();
    y = 10'sd16; tick();
    y_valid = 1'b0; tick();
    chk("fs_full", cnt1, 4);
    y_valid = 1'b1; y = 10'sd20; tick();
    y_valid = 1'b0; m_ready = 1'b1; tick();
    chk("fs_count", cnt1, 4);
    chk("fs_drop", drop1, 2);
    chk("fs_head", m_data1, 2);
    m_ready = 1'b0; y_valid = 1'b1; y = 10'sd24; tick();
    y_valid = 1'b0; clr_flags = 1'b1; tick();
    chk("fs_clr_drop", drop1, 1);
    chk("fs_clr_ovf", ovf1, 1);
    clr_flags = 1'b0; m_ready = 1'b1; tick();
    chk("fs_count3", cnt1, 3);
    chk("fs_head3", m_data1, 3);

    // Mid-operation reset with count=3, a sample in the stage and u2 at phase 1
    m_ready = 1'b0; y_valid = 1'b1; y = 10'sd28; tick();
    y_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mr_count1", cnt1, 0);
    chk("mr_valid1", m_valid1, 0);
    chk("mr_data1", m_data1, 0);
    chk("mr_drop1", drop1, 0);
    chk("mr_ovf1", ovf1, 0);
    chk("mr_count2", cnt2, 0);
    tick();
    rst = 1'b0; y_valid = 1'b1; y = 10'sd8; tick();
    y = 10'sd12; tick();
    y_valid = 1'b0;
    chk("mr_acc_c1", cnt1, 1);
    chk("mr_acc_d1", m_data1, 2);
    chk("mr_acc_c2", cnt2, 1);
    chk("mr_acc_d2", m_data2, 2);
    tick();
    chk("mr_next_c1", cnt1, 2);
    chk("mr_next_c2", cnt2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
